bt656_timing_decoder: RTL and testbench

//  Upstream stage of line_rotator. Parses an ITU-R BT.656 10-bit 4:2:2 stream, detects EAV/SAV timing

---
 rtl/bt656_timing_decoder_if.sv | 22 ++
 rtl/bt656_timing_decoder.sv | 174 +++++++++++++++++
 tb/tb_bt656_timing_decoder.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bt656_timing_decoder_if.sv
// Video bundle of the BT.656 timing decoder: the raw word stream in, and the delayed stream
// with regenerated H/V/F, lock and protection-error status out.
interface bt656_timing_decoder_if;
  logic [9:0] data_in;
  logic [9:0] data_out;
  logic       H;
  logic       V;
  logic       F;
  logic       timing_valid;
  logic       xyz_error;
  logic [7:0] error_count;

  modport master (
    output data_in,
    input  data_out, H, V, F, timing_valid, xyz_error, error_count
  );

  modport slave (
    input  data_in,
    output data_out, H, V, F, timing_valid, xyz_error, error_count
  );
endinterface

// File: rtl/bt656_timing_decoder.sv
// BT.656 timing decoder: finds EAV/SAV codes, validates XYZ protection, regenerates H/V/F aligned
// with the 4-word delayed stream, and qualifies lock with a line-length flywheel.
module bt656_timing_decoder #(
  parameter int LINE_WORDS    = 1716,
  parameter int LOCK_LINES    = 4,
  parameter int UNLOCK_MISSES = 2
) (
  input logic                   clk,
  input logic                   reset,
  bt656_timing_decoder_if.slave vid
);

  localparam int LINES_W  = $clog2(LOCK_LINES + 1);
  localparam int MISSES_W = $clog2(UNLOCK_MISSES + 1);
  localparam logic [10:0]         LINE_CNT   = 11'(LINE_WORDS);
  localparam logic [LINES_W-1:0]  LOCK_CNT   = LINES_W'(LOCK_LINES);
  localparam logic [MISSES_W-1:0] UNLOCK_CNT = MISSES_W'(UNLOCK_MISSES);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_e;

  logic [9:0]          w0;
  logic [9:0]          tap1_q, tap2_q, tap3_q, dataOut_q;
  logic [3:0]          savDly_q;
  logic                hFlag_q, hFlag_d;
  logic                vFlag_q, vFlag_d;
  logic                fFlag_q, fFlag_d;
  logic                xyzErr_q, xyzErr_d;
  logic [7:0]          errCnt_q, errCnt_d;
  logic [10:0]         cnt_q, cnt_d;
  state_e              state_q, state_d;
  logic [LINES_W-1:0]  lines_q, lines_d;
  logic [MISSES_W-1:0] misses_q, misses_d;
  logic                valid_q, valid_d;

  logic trs, xyzOk, goodEav, goodSav, atLine, miss;

  assign w0 = vid.data_in;

  // Low two bits are ignored so 8-bit sources padded with 00 or 11 still match.
  always_comb begin
    trs     = (tap3_q[9:2] == 8'hFF) && (tap2_q[9:2] == 8'h00) &&
              (tap1_q[9:2] == 8'h00) && w0[9];
    xyzOk   = (w0[5] == (w0[7] ^ w0[6])) && (w0[4] == (w0[8] ^ w0[6])) &&
              (w0[3] == (w0[8] ^ w0[7])) && (w0[2] == (w0[8] ^ w0[7] ^ w0[6]));
    goodEav = trs && xyzOk && w0[6];
    goodSav = trs && xyzOk && !w0[6];
    atLine  = (cnt_q == LINE_CNT);
  end

  always_comb begin
    hFlag_d = hFlag_q;
    vFlag_d = vFlag_q;
    fFlag_d = fFlag_q;
    if (goodEav) begin
      hFlag_d = 1'b1;
      vFlag_d = w0[7];
      fFlag_d = w0[8];
    end else if (savDly_q[3]) begin
      hFlag_d = 1'b0;
    end
    xyzErr_d = trs && !xyzOk;
    errCnt_d = (xyzErr_d && (errCnt_q != 8'hFF)) ? errCnt_q + 8'd1 : errCnt_q;
    if (goodEav || miss) begin
      cnt_d = 11'd1;
    end else if (cnt_q != 11'h7FF) begin
      cnt_d = cnt_q + 11'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // The SAV delay line holds H high until the first active sample reaches data_out.
  always_ff @(posedge clk) begin
    if (reset) begin
      tap1_q    <= '0;
      tap2_q    <= '0;
      tap3_q    <= '0;
      dataOut_q <= '0;
      savDly_q  <= '0;
      hFlag_q   <= 1'b1;
      vFlag_q   <= 1'b1;
      fFlag_q   <= 1'b0;
      xyzErr_q  <= 1'b0;
      errCnt_q  <= '0;
      cnt_q     <= '0;
    end else begin
      tap1_q    <= w0;
      tap2_q    <= tap1_q;
      tap3_q    <= tap2_q;
      dataOut_q <= tap3_q;
      savDly_q  <= {savDly_q[2:0], goodSav};
      hFlag_q   <= hFlag_d;
      vFlag_q   <= vFlag_d;
      fFlag_q   <= fFlag_d;
      xyzErr_q  <= xyzErr_d;
      errCnt_q  <= errCnt_d;
      cnt_q     <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= SEARCH;
      lines_q  <= '0;
      misses_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      lines_q  <= lines_d;
      misses_q <= misses_d;
      valid_q  <= valid_d;
    end
  end

  // A miss is either a flywheel timeout or an EAV at the wrong spacing; both restart the count.
  always_comb begin
    state_d  = state_q;
    lines_d  = lines_q;
    misses_d = misses_q;
    miss     = 1'b0;
    unique case (state_q)
      SEARCH: begin
        if (goodEav) begin
          state_d = VERIFY;
          lines_d = LINES_W'(1);
        end
      end
      VERIFY: begin
        if (goodEav) begin
          if (atLine) begin
            lines_d = lines_q + LINES_W'(1);
            if (lines_q + LINES_W'(1) == LOCK_CNT) begin
              state_d  = LOCKED;
              misses_d = '0;
            end
          end else begin
            lines_d = LINES_W'(1);
          end
        end else if (cnt_q > LINE_CNT) begin
          state_d = SEARCH;
        end
      end
      LOCKED: begin
        if (goodEav && atLine) begin
          misses_d = '0;
        end else if (goodEav || atLine) begin
          miss     = 1'b1;
          misses_d = misses_q + MISSES_W'(1);
          if (misses_q + MISSES_W'(1) == UNLOCK_CNT) begin
            state_d = SEARCH;
          end
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  always_comb begin
    valid_d = (state_q == LOCKED);
  end

  assign vid.data_out     = dataOut_q;
  assign vid.H            = hFlag_q;
  assign vid.V            = vFlag_q;
  assign vid.F            = fFlag_q;
  assign vid.timing_valid = valid_q;
  assign vid.xyz_error    = xyzErr_q;
  assign vid.error_count  = errCnt_q;

endmodule

// File: tb/tb_bt656_timing_decoder.sv
// Randomised bench for bt656_timing_decoder: builds BT.656 lines and compares every output
// against a word-history reference model, plus targeted checks at the interesting cycles.
module tb_bt656_timing_decoder;

  localparam int LINE    = 1716;
  localparam int LOCKN   = 4;
  localparam int UNLOCKN = 2;

  typedef enum int {M_SEARCH, M_VERIFY, M_LOCKED} mode_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  bt656_timing_decoder_if vid();

  bt656_timing_decoder #(
    .LINE_WORDS(LINE),
    .LOCK_LINES(LOCKN),
    .UNLOCK_MISSES(UNLOCKN)
  ) dut (
    .clk(clk),
    .reset(reset),
    .vid(vid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [9:0] hist[$];
  logic [9:0] lineQ[$];
  int         savDue[$];
  int         idx = 0;
  int         lastRef, runLines, missRun;
  mode_t      mode, modeBefore;
  logic [9:0] expData;
  logic       expH, expV, expF, expXyzErr;
  int         expErrCnt;
  logic [21:0] expVec, obsVec;

  function automatic logic [9:0] makeXyz(input bit f, input bit v, input bit h);
    return {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h, 2'b00};
  endfunction

  function automatic bit xyzGood(input logic [9:0] x);
    logic [9:0] ref10;
    ref10 = makeXyz(x[8], x[7], x[6]);
    return x[5:2] == ref10[5:2];
  endfunction

  // Legal sample range keeps random payload from ever forming a preamble.
  function automatic logic [9:0] randWord();
    return 10'($urandom_range(1019, 4));
  endfunction

  task automatic randCodes(output logic [9:0] eav, output logic [9:0] sav);
    bit f, v;
    f = bit'($urandom_range(1, 0));
    v = bit'($urandom_range(1, 0));
    eav = makeXyz(f, v, 1'b1);
    sav = makeXyz(f, v, 1'b0);
  endtask

  task automatic buildLine(input logic [9:0] eav, input logic [9:0] sav,
                           input int blank, input int total);
    lineQ.delete();
    lineQ.push_back(10'h3FF); lineQ.push_back(10'h000); lineQ.push_back(10'h000);
    lineQ.push_back(eav);
    for (int k = 0; k < blank; k++) lineQ.push_back(randWord());
    lineQ.push_back(10'h3FF); lineQ.push_back(10'h000); lineQ.push_back(10'h000);
    lineQ.push_back(sav);
    while (lineQ.size() < total) lineQ.push_back(randWord());
  endtask

  // Reference model: the cnt value at cycle idx is idx - lastRef.
  task automatic stepWord(input logic [9:0] w);
    bit trs, good, eav, sav, refNow;
    int sp;
    vid.data_in = w;
    @(posedge clk);
    hist.push_back(w);
    trs = (hist[0][9:2] == 8'hFF) && (hist[1][9:2] == 8'h00) &&
          (hist[2][9:2] == 8'h00) && w[9];
    good = trs && xyzGood(w);
    eav  = good && w[6];
    sav  = good && !w[6];
    expData = hist[0];
    hist.delete(0);
    expXyzErr = trs && !good;
    if (expXyzErr && expErrCnt < 255) expErrCnt++;
    if (eav) begin
      expH = 1'b1; expV = w[7]; expF = w[8];
    end else if (savDue.size() > 0 && savDue[0] == idx) begin
      expH = 1'b0;
    end
    if (savDue.size() > 0 && savDue[0] == idx) savDue.delete(0);
    if (sav) savDue.push_back(idx + 4);
    sp = idx - lastRef;
    refNow = eav;
    modeBefore = mode;
    case (mode)
      M_SEARCH: if (eav) begin mode = M_VERIFY; runLines = 1; end
      M_VERIFY: begin
        if (eav) begin
          runLines = (sp == LINE) ? runLines + 1 : 1;
          if (runLines == LOCKN) begin mode = M_LOCKED; missRun = 0; end
        end else if (sp > LINE) begin
          mode = M_SEARCH;
        end
      end
      default: begin
        if (eav && sp == LINE) begin
          missRun = 0;
        end else if (eav || sp == LINE) begin
          refNow = 1'b1;
          missRun++;
          if (missRun == UNLOCKN) mode = M_SEARCH;
        end
      end
    endcase
    if (refNow) lastRef = idx;
    idx++;
    #1;
    obsVec = {vid.data_out, vid.H, vid.V, vid.F, vid.xyz_error, vid.error_count};
    expVec = {expData, expH, expV, expF, expXyzErr, 8'(expErrCnt)};
  endtask

  task automatic resetDut();
    reset = 1'b1;
    vid.data_in = randWord();
    @(posedge clk);
    #1;
    reset = 1'b0;
    hist.delete();
    repeat (3) hist.push_back(10'h000);
    savDue.delete();
    expData = '0; expH = 1'b1; expV = 1'b1; expF = 1'b0; expXyzErr = 1'b0; expErrCnt = 0;
    mode = M_SEARCH; modeBefore = M_SEARCH; runLines = 0; missRun = 0; lastRef = idx;
  endtask

  task automatic test_reset();
    resetDut();
    checks++;
    if (vid.data_out !== 10'h000) begin errors++; $display("[TB] FAIL reset_data: got %h, expected 000", vid.data_out); end
    checks++;
    if ({vid.H, vid.V, vid.F} !== 3'b110) begin errors++; $display("[TB] FAIL reset_hvf: got %b, expected 110", {vid.H, vid.V, vid.F}); end
    checks++;
    if (vid.timing_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b, expected 0", vid.timing_valid); end
    checks++;
    if (vid.xyz_error !== 1'b0 || vid.error_count !== 8'd0) begin
      errors++; $display("[TB] FAIL reset_err: got %b/%0d, expected 0/0", vid.xyz_error, vid.error_count);
    end
  endtask

  task automatic test_basic_line();
    logic [9:0] expOut;
    int p;
    resetDut();
    buildLine(10'h274, 10'h200, 270, 578);
    p = 274;
    foreach (lineQ[i]) begin
      stepWord(lineQ[i]);
      checks++;
      if (obsVec !== expVec) begin errors++; $display("[TB] FAIL basic_stream at %0d: got %h, expected %h", i, obsVec, expVec); end
      expOut = (i >= 3) ? lineQ[i-3] : 10'h000;
      checks++;
      if (vid.data_out !== expOut) begin errors++; $display("[TB] FAIL basic_delay at %0d: got %h, expected %h", i, vid.data_out, expOut); end
      if (i == 3 || i == p + 6) begin
        checks++;
        if (vid.H !== 1'b1) begin errors++; $display("[TB] FAIL basic_h_high at %0d: got %b, expected 1", i, vid.H); end
      end
      if (i == p + 7) begin
        checks++;
        if (vid.H !== 1'b0 || vid.data_out !== lineQ[p+4]) begin
          errors++;
          $display("[TB] FAIL basic_h_fall: got H=%b data=%h, expected H=0 data=%h", vid.H, vid.data_out, lineQ[p+4]);
        end
      end
    end
  endtask

  task automatic test_lock();
    logic [9:0] eav, sav;
    resetDut();
    for (int l = 0; l < 5; l++) begin
      randCodes(eav, sav);
      buildLine(eav, sav, 268, LINE);
      foreach (lineQ[i]) begin
        stepWord(lineQ[i]);
        checks++;
        if (obsVec !== expVec) begin errors++; $display("[TB] FAIL lock_stream at %0d: got %h, expected %h", idx, obsVec, expVec); end
        if (modeBefore == mode) begin
          checks++;
          if (vid.timing_valid !== (mode == M_LOCKED)) begin
            errors++; $display("[TB] FAIL lock_valid at %0d: got %b, expected %b", idx, vid.timing_valid, mode == M_LOCKED);
          end
        end
        if (l == 3 && (i == 0 || i == 4)) begin
          checks++;
          if (vid.timing_valid !== (i == 4)) begin
            errors++; $display("[TB] FAIL lock_edge at word %0d: got %b, expected %b", i, vid.timing_valid, i == 4);
          end
        end
      end
    end
  endtask

  task automatic test_xyz_error();
    logic [9:0] eav, sav;
    for (int l = 0; l < 5; l++) begin
      randCodes(eav, sav);
      if (l == 0) eav = 10'h3C4;
      if (l == 1) eav = 10'h27C;
      if (l >= 3) eav = eav ^ 10'h008;
      buildLine(eav, sav, 268, LINE);
      foreach (lineQ[i]) begin
        stepWord(lineQ[i]);
        checks++;
        if (obsVec !== expVec) begin errors++; $display("[TB] FAIL xyz_stream at %0d: got %h, expected %h", idx, obsVec, expVec); end
        if (modeBefore == mode) begin
          checks++;
          if (vid.timing_valid !== (mode == M_LOCKED)) begin
            errors++; $display("[TB] FAIL xyz_valid at %0d: got %b, expected %b", idx, vid.timing_valid, mode == M_LOCKED);
          end
        end
        if (l == 1 && i == 3) begin
          checks++;
          if ({vid.xyz_error, vid.error_count, vid.V, vid.F} !== {1'b1, 8'd1, 1'b1, 1'b1}) begin
            errors++;
            $display("[TB] FAIL xyz_pulse: got err=%b cnt=%0d V=%b F=%b, expected 1 1 1 1", vid.xyz_error, vid.error_count, vid.V, vid.F);
          end
        end
      end
      if (l == 2 || l == 4) begin
        checks++;
        if (vid.timing_valid !== (l == 2)) begin
          errors++; $display("[TB] FAIL xyz_lock after line %0d: got %b, expected %b", l, vid.timing_valid, l == 2);
        end
      end
    end
  endtask

  task automatic test_reset_midline();
    logic [9:0] eav, sav;
    resetDut();
    for (int l = 0; l < 5; l++) begin
      randCodes(eav, sav);
      if (l == 0) sav = sav ^ 10'h004;
      buildLine(eav, sav, 268, LINE);
      foreach (lineQ[i]) begin
        if (l == 4 && i == 330) break;
        stepWord(lineQ[i]);
        checks++;
        if (obsVec !== expVec) begin errors++; $display("[TB] FAIL mid_stream at %0d: got %h, expected %h", idx, obsVec, expVec); end
      end
      if (l == 0) begin
        checks++;
        if (vid.H !== 1'b1 || vid.error_count !== 8'd1) begin
          errors++; $display("[TB] FAIL bad_sav_line: got H=%b cnt=%0d, expected H=1 cnt=1", vid.H, vid.error_count);
        end
      end
    end
    checks++;
    if (vid.H !== 1'b0 || vid.timing_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL mid_active: got H=%b valid=%b, expected H=0 valid=1", vid.H, vid.timing_valid);
    end
    resetDut();
    checks++;
    if ({vid.H, vid.data_out, vid.timing_valid, vid.error_count} !== {1'b1, 10'h000, 1'b0, 8'd0}) begin
      errors++;
      $display("[TB] FAIL mid_reset: got H=%b data=%h valid=%b cnt=%0d, expected 1 000 0 0", vid.H, vid.data_out, vid.timing_valid, vid.error_count);
    end
  endtask

  task automatic test_short_lines();
    logic [9:0] eav, sav;
    int len;
    resetDut();
    for (int l = 0; l < 7; l++) begin
      randCodes(eav, sav);
      len = (l == 4 || l == 5) ? 1700 : LINE;
      buildLine(eav, sav, 268, len);
      foreach (lineQ[i]) begin
        stepWord(lineQ[i]);
        checks++;
        if (obsVec !== expVec) begin errors++; $display("[TB] FAIL short_stream at %0d: got %h, expected %h", idx, obsVec, expVec); end
        if (modeBefore == mode) begin
          checks++;
          if (vid.timing_valid !== (mode == M_LOCKED)) begin
            errors++; $display("[TB] FAIL short_valid at %0d: got %b, expected %b", idx, vid.timing_valid, mode == M_LOCKED);
          end
        end
      end
      if (l >= 4) begin
        checks++;
        if (vid.timing_valid !== (l != 6)) begin
          errors++; $display("[TB] FAIL short_lock after line %0d: got %b, expected %b", l, vid.timing_valid, l != 6);
        end
      end
    end
  endtask

  task automatic test_field_and_8bit();
    resetDut();
    for (int l = 0; l < 2; l++) begin
      if (l == 0) begin
        buildLine(10'h3C4, makeXyz(1'b1, 1'b1, 1'b0), 268, LINE);
      end else begin
        buildLine(10'h276, makeXyz(1'b0, 1'b0, 1'b0), 268, 800);
        lineQ[0] = 10'h3FC;
        lineQ[2] = 10'h003;
      end
      foreach (lineQ[i]) begin
        stepWord(lineQ[i]);
        checks++;
        if (obsVec !== expVec) begin errors++; $display("[TB] FAIL field_stream at %0d: got %h, expected %h", idx, obsVec, expVec); end
        if (i == 3) begin
          checks++;
          if ({vid.F, vid.V, vid.xyz_error} !== {(l == 0), (l == 0), 1'b0}) begin
            errors++;
            $display("[TB] FAIL field_flags line %0d: got F=%b V=%b err=%b, expected F=%b V=%b err=0", l, vid.F, vid.V, vid.xyz_error, l == 0, l == 0);
          end
        end
      end
    end
  endtask

  initial begin
    vid.data_in = 10'h000;
    test_reset();
    test_basic_line();
    test_lock();
    test_xyz_error();
    test_reset_midline();
    test_short_lines();
    test_field_and_8bit();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
